uart_tx_param: RTL and testbench

Parametrised UART transmitter, the successor to the single-byte serialiser on the peripheral bus. Write requests on the req/we bus push characters into an internal TX FIFO. A baud-divided serialiser then sends each character as a frame: start bit, DATA_BITS data bits LSB first, an optional parity bit, and 1 or 2 stop bits. Frames go out back-to-back while the FIFO holds data.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_param_if.sv | 25 ++
 rtl/uart_fifo.sv | 60 ++++++
 rtl/uart_tx_param.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared serialiser state type, parity constants, frame length
// Rev 1.0
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam logic c_PARITY_EVEN = 1'b0;
   localparam logic c_PARITY_ODD  = 1'b1;

   function automatic int frame_cycles(input int clk_div, input int data_bits,
                                       input int parity_en, input int stop_bits);
      return clk_div * (1 + data_bits + parity_en + stop_bits);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_param_if.sv
`default_nettype none
// ============================================================================
// uart_tx_param_if : peripheral-bus write port of the UART transmitter
// Rev 1.0
// ============================================================================
interface uart_tx_param_if;

   logic        req_i;
   logic        we_i;
   logic [31:0] DATA_i;
   logic        ready_o;
   logic        overflow_o;

   modport master (
      output req_i, we_i, DATA_i,
      input  ready_o, overflow_o
   );

   modport slave (
      input  req_i, we_i, DATA_i,
      output ready_o, overflow_o
   );

endinterface
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// uart_fifo : synchronous FIFO, full/empty derived from the occupancy count
// Rev 1.0
// ============================================================================
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  wire logic                       CLOCK,
   input  wire logic                       RESET_N,
   input  wire logic                       push,
   input  wire logic                       pop,
   input  wire logic [WIDTH-1:0]           wr_data,
   output logic      [WIDTH-1:0]           rd_data,
   output logic                            full,
   output logic                            empty,
   output logic      [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign full    = (r_count == CNT_W'(DEPTH));
   assign empty   = (r_count == '0);
   assign count   = r_count;
   assign rd_data = r_mem[r_rd_ptr];
   assign w_push  = push & ~full;
   assign w_pop   = pop & ~empty;

   // Pointers are exactly log2(DEPTH) wide so they wrap without extra logic
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge CLOCK) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// uart_tx_param : FIFO-buffered, baud-divided UART transmitter
// Rev 1.0
// ============================================================================
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  wire logic                            CLOCK,
   input  wire logic                            RESET_N,
   uart_tx_param_if.slave                       bus,
   output logic                                 busy_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count_o,
   output logic                                 done_o,
   output logic                                 OUT_o
);

   localparam int   BAUD_W     = $clog2(CLK_DIV);
   localparam int   BIT_W      = 3;
   localparam logic c_PAR_INIT = (PARITY_ODD != 0) ? c_PARITY_ODD : c_PARITY_EVEN;

   uart_state_t          r_state, w_state_nxt;
   logic [BAUD_W-1:0]    r_baud, w_baud_nxt;
   logic [BIT_W-1:0]     r_bit, w_bit_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic                 r_par, w_par_nxt;
   logic                 r_overflow;

   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [DATA_BITS-1:0] w_fifo_head;
   logic                 w_wr_req;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_baud_end;
   logic                 w_head_par;
   logic                 w_done;
   logic                 w_out;
   logic                 w_unused_data;

   assign w_wr_req      = bus.req_i & bus.we_i;
   assign w_push        = w_wr_req & ~w_fifo_full;
   assign w_head_par    = (^w_fifo_head) ^ c_PAR_INIT;
   assign w_baud_end    = (r_baud == BAUD_W'(CLK_DIV - 1));
   assign w_unused_data = &{1'b0, bus.DATA_i};

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .push    (w_push),
      .pop     (w_pop),
      .wr_data (bus.DATA_i[DATA_BITS-1:0]),
      .rd_data (w_fifo_head),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty),
      .count   (fifo_count_o)
   );

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= IDLE;
         r_baud     <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud     <= w_baud_nxt;
         r_bit      <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_par      <= w_par_nxt;
         r_overflow <= w_wr_req & w_fifo_full;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_pop       = 1'b0;
      w_done      = 1'b0;
      w_out       = 1'b1;

      if (r_state != IDLE) begin
         w_baud_nxt = w_baud_end ? '0 : r_baud + BAUD_W'(1);
      end

      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_fifo_head;
               w_par_nxt   = w_head_par;
               w_state_nxt = START;
            end
         end
         START: begin
            w_out = 1'b0;
            if (w_baud_end) begin
               w_state_nxt = DATA;
               w_bit_nxt   = '0;
            end
         end
         DATA: begin
            w_out = r_shift[0];
            if (w_baud_end) begin
               if (r_bit == BIT_W'(DATA_BITS - 1)) begin
                  w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                  w_bit_nxt   = '0;
               end else begin
                  w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                  w_bit_nxt   = r_bit + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            w_out = r_par;
            if (w_baud_end) begin
               w_state_nxt = STOP;
               w_bit_nxt   = '0;
            end
         end
         STOP: begin
            // Last stop cycle chains straight into the next START when data waits
            if (w_baud_end && (r_bit == BIT_W'(STOP_BITS - 1))) begin
               w_done    = 1'b1;
               w_bit_nxt = '0;
               if (!w_fifo_empty) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_fifo_head;
                  w_par_nxt   = w_head_par;
                  w_state_nxt = START;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (w_baud_end) begin
               w_bit_nxt = r_bit + BIT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign bus.ready_o    = ~w_fifo_full;
   assign bus.overflow_o = r_overflow;
   assign busy_o         = (r_state != IDLE);
   assign done_o         = w_done;
   assign OUT_o          = w_out;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_param : directed bench over four UART configurations
// Rev 1.0
// ============================================================================
module tb_uart_tx_param;
   import uart_pkg::*;

   localparam int         CLK_DIV = 4;
   localparam logic [3:0] PEN     = 4'b0110;
   localparam logic [3:0] PODD    = 4'b0100;

   logic            CLOCK;
   logic            RESET_N;
   logic [3:0]      req_v, we_v;
   logic [31:0]     data_v;
   logic [3:0]      rdy_v, ovf_v, busy_v, done_v, out_v;
   logic [3:0][2:0] cnt_v;

   int compared;
   int mismatched;

   // dut 0: 8N1, dut 1: 8E1, dut 2: 8O1, dut 3: 5N2
   for (genvar g = 0; g < 4; g++) begin : g_dut
      uart_tx_param_if bus ();
      assign bus.req_i  = req_v[g];
      assign bus.we_i   = we_v[g];
      assign bus.DATA_i = data_v;
      assign rdy_v[g]   = bus.ready_o;
      assign ovf_v[g]   = bus.overflow_o;

      uart_tx_param #(
         .CLK_DIV    (CLK_DIV),
         .DATA_BITS  ((g == 3) ? 5 : 8),
         .FIFO_DEPTH (4),
         .PARITY_EN  (PEN[g] ? 1 : 0),
         .PARITY_ODD (PODD[g] ? 1 : 0),
         .STOP_BITS  ((g == 3) ? 2 : 1)
      ) dut (
         .CLOCK        (CLOCK),
         .RESET_N      (RESET_N),
         .bus          (bus),
         .busy_o       (busy_v[g]),
         .fifo_count_o (cnt_v[g]),
         .done_o       (done_v[g]),
         .OUT_o        (out_v[g])
      );
   end

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   int   mon_busy;
   int   mon_done;
   logic mon_log[$];
   int   mon_done_at[$];

   always @(negedge CLOCK) begin
      if (busy_v[0] === 1'b1) begin
         mon_log.push_back(out_v[0]);
         if (done_v[0] === 1'b1) mon_done_at.push_back(mon_busy);
         mon_busy++;
      end
      if (done_v[0] === 1'b1) mon_done++;
   end

   task automatic mon_clear();
      mon_busy = 0;
      mon_done = 0;
      mon_log.delete();
      mon_done_at.delete();
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic do_write(input int sel, input logic [31:0] d);
      req_v[sel] = 1'b1;
      we_v[sel]  = 1'b1;
      data_v     = d;
      tick();
      req_v[sel] = 1'b0;
      we_v[sel]  = 1'b0;
   endtask

   task automatic wait_idle(input int sel, input int budget, input string name);
      int n = 0;
      while (busy_v[sel] === 1'b1 && n < budget) begin
         tick();
         n++;
      end
      compared++;
      if (busy_v[sel] !== 1'b0) begin
         mismatched++;
         $display("FAIL %s timeout: busy=%b after %0d cycles, expected 0", name, busy_v[sel], n);
      end
   endtask

   // frame bit 0 is the start bit; lead = ticks before frame cycle 1
   task automatic check_frame(input int sel, input logic [15:0] frame, input int nbits,
                              input int lead, input bit expect_idle, input string name);
      int   n = nbits * CLK_DIV;
      logic exp_done;
      repeat (lead) tick();
      for (int i = 0; i < n; i++) begin
         exp_done = (i == n - 1);
         compared++;
         if (out_v[sel] !== frame[i / CLK_DIV] || done_v[sel] !== exp_done || busy_v[sel] !== 1'b1) begin
            mismatched++;
            $display("FAIL %s cycle %0d: out=%b done=%b busy=%b, expected out=%b done=%b busy=1",
                     name, i + 1, out_v[sel], done_v[sel], busy_v[sel], frame[i / CLK_DIV], exp_done);
         end
         tick();
      end
      compared++;
      if (expect_idle) begin
         if (busy_v[sel] !== 1'b0 || out_v[sel] !== 1'b1) begin
            mismatched++;
            $display("FAIL %s end: busy=%b out=%b, expected busy=0 out=1", name, busy_v[sel], out_v[sel]);
         end
      end else if (busy_v[sel] !== 1'b1 || out_v[sel] !== 1'b0) begin
         mismatched++;
         $display("FAIL %s chain: busy=%b out=%b, expected busy=1 out=0", name, busy_v[sel], out_v[sel]);
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      repeat (3) tick();
      for (int s = 0; s < 4; s++) begin
         compared++;
         if (out_v[s] !== 1'b1 || busy_v[s] !== 1'b0 || done_v[s] !== 1'b0 ||
             ovf_v[s] !== 1'b0 || cnt_v[s] !== 3'd0 || rdy_v[s] !== 1'b1) begin
            mismatched++;
            $display("FAIL reset dut%0d: out=%b busy=%b done=%b ovf=%b cnt=%0d rdy=%b, expected 1 0 0 0 0 1",
                     s, out_v[s], busy_v[s], done_v[s], ovf_v[s], cnt_v[s], rdy_v[s]);
         end
      end
      RESET_N = 1'b1;
      tick();
   endtask

   task automatic test_read_ignored();
      req_v[0] = 1'b1;
      we_v[0]  = 1'b0;
      data_v   = 32'h99;
      repeat (3) tick();
      req_v[0] = 1'b0;
      tick();
      compared++;
      if (cnt_v[0] !== 3'd0 || busy_v[0] !== 1'b0 || out_v[0] !== 1'b1 || ovf_v[0] !== 1'b0) begin
         mismatched++;
         $display("FAIL read_ignored: cnt=%0d busy=%b out=%b ovf=%b, expected 0 0 1 0",
                  cnt_v[0], busy_v[0], out_v[0], ovf_v[0]);
      end
   endtask

   task automatic test_basic();
      do_write(0, 32'hFFFF_FFA5);
      compared++;
      if (cnt_v[0] !== 3'd1 || out_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
         mismatched++;
         $display("FAIL basic_latency: cnt=%0d out=%b busy=%b, expected 1 1 0", cnt_v[0], out_v[0], busy_v[0]);
      end
      check_frame(0, 16'b00_0000_1101001010, 10, 1, 1'b1, "basic_A5");
      compared++;
      if (cnt_v[0] !== 3'd0) begin
         mismatched++;
         $display("FAIL basic_count: cnt=%0d, expected 0", cnt_v[0]);
      end
   endtask

   task automatic test_parity();
      do_write(1, 32'h07);
      check_frame(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1, 1'b1, "parity_even_07");
      do_write(2, 32'h07);
      check_frame(2, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1, 1'b1, "parity_odd_07");
   endtask

   task automatic test_reduced();
      do_write(3, 32'hFF);
      check_frame(3, 16'b0000_0000_1111_1110, 8, 1, 1'b1, "reduced_FF");
      do_write(3, 32'hE0);
      check_frame(3, 16'b0000_0000_1100_0000, 8, 1, 1'b1, "reduced_E0");
   endtask

   task automatic test_overflow();
      int          exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
      logic [9:0]  cap;
      logic [9:0]  exp_f;
      logic [7:0]  b;
      mon_clear();
      for (int w = 0; w < 6; w++) begin
         do_write(0, 32'(w + 1));
         compared++;
         if (cnt_v[0] !== 3'(exp_cnt[w])) begin
            mismatched++;
            $display("FAIL overflow_count write %0d: cnt=%0d, expected %0d", w + 1, cnt_v[0], exp_cnt[w]);
         end
         if (w == 4) begin
            compared++;
            if (rdy_v[0] !== 1'b0 || ovf_v[0] !== 1'b0) begin
               mismatched++;
               $display("FAIL overflow_full: rdy=%b ovf=%b, expected 0 0", rdy_v[0], ovf_v[0]);
            end
         end
      end
      compared++;
      if (ovf_v[0] !== 1'b1) begin
         mismatched++;
         $display("FAIL overflow_pulse: ovf=%b, expected 1", ovf_v[0]);
      end
      tick();
      compared++;
      if (ovf_v[0] !== 1'b0) begin
         mismatched++;
         $display("FAIL overflow_pulse_end: ovf=%b, expected 0", ovf_v[0]);
      end
      wait_idle(0, 5 * frame_cycles(CLK_DIV, 8, 0, 1) + 20, "overflow_drain");
      compared++;
      if (mon_busy != 200 || mon_done != 5) begin
         mismatched++;
         $display("FAIL overflow_train: busy_cycles=%0d done_pulses=%0d, expected 200 5", mon_busy, mon_done);
      end
      compared++;
      if (mon_done_at.size() != 5 || mon_log.size() < 200) begin
         mismatched++;
         $display("FAIL overflow_log: done_entries=%0d log=%0d, expected 5 200", mon_done_at.size(), mon_log.size());
      end else begin
         for (int f = 0; f < 5; f++) begin
            b     = 8'(f + 1);
            exp_f = {1'b1, b, 1'b0};
            for (int k = 0; k < 10; k++) cap[k] = mon_log[f * 40 + k * 4 + 2];
            compared++;
            if (cap !== exp_f || mon_done_at[f] != f * 40 + 39) begin
               mismatched++;
               $display("FAIL overflow_frame %0d: bits=%b done_at=%0d, expected bits=%b done_at=%0d",
                        f, cap, mon_done_at[f], exp_f, f * 40 + 39);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      do_write(0, 32'h11);
      tick();
      do_write(0, 32'h22);
      compared++;
      if (cnt_v[0] !== 3'd1) begin
         mismatched++;
         $display("FAIL simul_queued: cnt=%0d, expected 1", cnt_v[0]);
      end
      repeat (38) tick();
      compared++;
      if (done_v[0] !== 1'b1) begin
         mismatched++;
         $display("FAIL simul_last_stop: done=%b, expected 1", done_v[0]);
      end
      do_write(0, 32'h33);
      compared++;
      if (cnt_v[0] !== 3'd1 || out_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
         mismatched++;
         $display("FAIL simul_pushpop: cnt=%0d out=%b busy=%b, expected 1 0 1", cnt_v[0], out_v[0], busy_v[0]);
      end
      check_frame(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, 0, 1'b0, "simul_22");
      check_frame(0, {6'b0, 1'b1, 8'h33, 1'b0}, 10, 0, 1'b1, "simul_33");
   endtask

   task automatic test_reset_mid();
      mon_clear();
      do_write(0, 32'hA5);
      do_write(0, 32'h3C);
      repeat (17) tick();
      compared++;
      if (out_v[0] !== 1'b0 || cnt_v[0] !== 3'd1) begin
         mismatched++;
         $display("FAIL reset_mid_pre: out=%b cnt=%0d, expected 0 1", out_v[0], cnt_v[0]);
      end
      #2;
      RESET_N = 1'b0;
      #1;
      compared++;
      if (out_v[0] !== 1'b1 || cnt_v[0] !== 3'd0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_mid_async: out=%b cnt=%0d busy=%b done=%b, expected 1 0 0 0",
                  out_v[0], cnt_v[0], busy_v[0], done_v[0]);
      end
      repeat (2) tick();
      RESET_N = 1'b1;
      tick();
      compared++;
      if (mon_done != 0 || out_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_mid_post: done_pulses=%0d out=%b busy=%b, expected 0 1 0",
                  mon_done, out_v[0], busy_v[0]);
      end
      do_write(0, 32'h55);
      check_frame(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, 1, 1'b1, "reset_recover_55");
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      req_v      = '0;
      we_v       = '0;
      data_v     = '0;
      RESET_N    = 1'b0;
      mon_clear();
      test_reset();
      test_read_ignored();
      test_basic();
      test_parity();
      test_reduced();
      test_overflow();
      test_simultaneous();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
